alu_parity_pipe: RTL
====================

# alu_parity_pipe

Parametrised two-stage pipelined encoder/ALU/parity unit with valid/ready flow control. It accepts a one-hot function code and two WIDTH-bit operands per transaction, encodes the function to a 3-bit opcode, executes one of eight ALU operations and emits the registered result with carry, parity and an illegal-code flag. Backpressure is supported at full throughput of one transaction per cycle. It sits between an operand source (register file or testbench driver) and any consumer of ALU results.

## Interface
- WIDTH, 4: operand and result width, ≥ 2.
- ODD_PARITY, 0: 0 gives even parity (parity = XOR-reduce of result); 1 gives the inverted value.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  unit can accept an input this cycle.
- fncode  input  8  one-hot function select.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result this cycle.
- result  output  WIDTH  ALU result.
- carry  output  1  carry/not-borrow for ADD/SUB; 0 for all other operations.
- parity  output  1  parity of result per ODD_PARITY.
- illegal  output  1  fncode was not exactly one-hot.

## Operation
- Encoder (combinational): opcode = index of the lowest set bit of fncode. illegal = 1 if the popcount of fncode is not 1. fncode = 0 gives opcode 0 and illegal = 1.
- Opcodes:
  - 0 ADD: {carry, result} = a + b, computed at WIDTH+1 bits.
  - 1 SUB: {carry, result} = a + ~b + 1; carry = 1 means no borrow.
  - 2 XOR.
  - 3 OR.
  - 4 AND.
  - 5 NOR.
  - 6 NAND.
  - 7 XNOR.
  - All results are truncated to WIDTH bits.
- Stage S1 register: {s1_valid, opcode, a, b, illegal}. It loads when in_valid && in_ready.
- Stage S2 register: {s2_valid, result, carry, parity, illegal}. It loads from the S1 ALU/parity logic when s1_valid && s2_advance.
- Outputs are driven directly from S2. out_valid = s2_valid.
- s2_advance = !s2_valid || out_ready.
- in_ready = !s1_valid || s2_advance. This is combinational from out_ready, with no bubble.
- Valid bits:
  - s1_valid clears when S1 drains with no new input.
  - s2_valid clears when out_ready is high and S1 is empty.
- Illegal codes are not dropped. They flow through with the computed result and the illegal flag set.
- While out_valid && !out_ready, S2 content is held stable. While S1 is stalled, S1 is held.

## Timing
- Reset (asynchronous, immediate): s1_valid = 0, s2_valid = 0, and all data registers 0. Consequently out_valid = 0, result = 0, carry = 0, parity = 0, illegal = 0, and in_ready = 1.
- Latency: input accepted at edge N gives out_valid high after edge N+1. The result is consumable at edge N+2 at the earliest.
- Throughput: one transaction per cycle while out_ready = 1.
- Full condition: both stages valid and out_ready = 0 gives in_ready = 0.
- Simultaneous events: in the same cycle, an input accept, an S1 → S2 move and an output take all occur together.
- Reset asserted mid-stream discards both stages. No output appears after rst_n deasserts until new input.
- in_valid without in_ready is ignored. The driver holds its data.

## Test plan
- Reset: rst_n = 0 mid-transfer → out_valid = 0, result = 0, and in_ready = 1 asynchronously, before the next clk edge.
- ADD, WIDTH = 4: fncode = 8'h01, a = 9, b = 8 → two cycles later result = 4'h1, carry = 1, parity = 1, illegal = 0.
- SUB: fncode = 8'h02, a = 3, b = 5 → result = 4'hE, carry = 0, parity = 1.
- SUB: a = 5, b = 3 → result = 4'h2, carry = 1.
- Logic ops: fncode = 8'h04, a = F, b = 5 → result = 4'hA, parity = 0.
- Logic ops: fncode = 8'h80, a = F, b = 5 → result = 4'h5.
- Logic ops: same case with ODD_PARITY = 1 → parity = 1.
- Illegal codes: fncode = 8'h0C → opcode 2 (XOR) and illegal = 1. fncode = 8'h00 → ADD and illegal = 1.
- Backpressure: hold out_ready = 0 and offer 3 back-to-back inputs → 2 are accepted, then in_ready = 0 and the result stays stable. Raise out_ready → results emerge in order, one per cycle, and the 3rd input is accepted in the same cycle the first result is taken.
- Streaming: 16 random transactions with out_ready = 1 → one result per cycle after 2-cycle latency, all matching the reference model.

Source files
------------

// File: rtl/alu_parity_pipe.sv
// Two-stage valid/ready pipeline: one-hot function encoder and operand capture in S1,
// ALU result with carry, parity and illegal-code flag registered in S2.
module alu_parity_pipe #(
    parameter int WIDTH      = 4,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       fncode,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             parity,
    output logic             illegal
);

    function automatic logic calc_parity(input logic [WIDTH-1:0] value);
        calc_parity = (^value) ^ ODD_PARITY;
    endfunction

    logic [2:0]       opcode_s;
    logic [3:0]       ones_s;
    logic             illegal_s;
    logic             s2_advance_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_carry_s;

    logic             s1_valid_r;
    logic [2:0]       s1_op_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic             s1_ill_r;

    logic             s2_valid_r;
    logic [WIDTH-1:0] s2_res_r;
    logic             s2_carry_r;
    logic             s2_par_r;
    logic             s2_ill_r;

    // Encoder: scanning high-to-low leaves the lowest set bit as the opcode.
    always_comb begin
        opcode_s = 3'd0;
        ones_s   = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            opcode_s = fncode[i] ? 3'(i) : opcode_s;
            ones_s   = ones_s + {3'd0, fncode[i]};
        end
        illegal_s = (ones_s != 4'd1);
    end

    assign s2_advance_s = !s2_valid_r || out_ready;
    assign in_ready     = !s1_valid_r || s2_advance_s;

    // ALU operating on the S1 operands; carry is meaningful only for ADD/SUB.
    always_comb begin
        sum_s       = {(WIDTH+1){1'b0}};
        alu_res_s   = {WIDTH{1'b0}};
        alu_carry_s = 1'b0;
        case (s1_op_r)
            3'd0: begin
                sum_s       = {1'b0, s1_a_r} + {1'b0, s1_b_r};
                alu_res_s   = sum_s[WIDTH-1:0];
                alu_carry_s = sum_s[WIDTH];
            end
            3'd1: begin
                sum_s       = {1'b0, s1_a_r} + {1'b0, ~s1_b_r} + {{WIDTH{1'b0}}, 1'b1};
                alu_res_s   = sum_s[WIDTH-1:0];
                alu_carry_s = sum_s[WIDTH];
            end
            3'd2:    alu_res_s = s1_a_r ^ s1_b_r;
            3'd3:    alu_res_s = s1_a_r | s1_b_r;
            3'd4:    alu_res_s = s1_a_r & s1_b_r;
            3'd5:    alu_res_s = ~(s1_a_r | s1_b_r);
            3'd6:    alu_res_s = ~(s1_a_r & s1_b_r);
            3'd7:    alu_res_s = ~(s1_a_r ^ s1_b_r);
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Stage 1: capture on handshake, drain when S2 takes the entry with nothing new arriving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 3'd0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_ill_r   <= 1'b0;
        end else if (in_valid && in_ready) begin
            s1_valid_r <= 1'b1;
            s1_op_r    <= opcode_s;
            s1_a_r     <= src_a;
            s1_b_r     <= src_b;
            s1_ill_r   <= illegal_s;
        end else if (s2_advance_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: holds its content while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_res_r   <= {WIDTH{1'b0}};
            s2_carry_r <= 1'b0;
            s2_par_r   <= 1'b0;
            s2_ill_r   <= 1'b0;
        end else if (s2_advance_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_res_r   <= alu_res_s;
                s2_carry_r <= alu_carry_s;
                s2_par_r   <= calc_parity(alu_res_s);
                s2_ill_r   <= s1_ill_r;
            end
        end
    end

    assign out_valid = s2_valid_r;
    assign result    = s2_res_r;
    assign carry     = s2_carry_r;
    assign parity    = s2_par_r;
    assign illegal   = s2_ill_r;

endmodule
